// File: rtl/seven_segment_pkg.sv
// Shared constants and types for the two-digit seven-segment bus decoder.
// Segment bit order is bit0=a ... bit6=g, active-high.
package seven_segment_pkg;

  localparam logic [6:0] SEG_DIGIT_0 = 7'h3F;
  localparam logic [6:0] SEG_DIGIT_1 = 7'h06;
  localparam logic [6:0] SEG_DIGIT_2 = 7'h5B;
  localparam logic [6:0] SEG_DIGIT_3 = 7'h4F;
  localparam logic [6:0] SEG_DIGIT_4 = 7'h66;
  localparam logic [6:0] SEG_DIGIT_5 = 7'h6D;
  localparam logic [6:0] SEG_DIGIT_6 = 7'h7C;
  localparam logic [6:0] SEG_DIGIT_7 = 7'h07;
  localparam logic [6:0] SEG_DIGIT_8 = 7'h7F;
  localparam logic [6:0] SEG_DIGIT_9 = 7'h67;
  localparam logic [6:0] SEG_BLANK   = 7'h00;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    StSync,
    StUnit,
    StTen
  } dec_state_e;

  typedef struct packed {
    logic       legal;
    logic [3:0] value;
  } bcd_t;

  // Forward mapping, used by the driver side and its bench; 4'hF and
  // out-of-range codes produce a blank pattern.
  function automatic logic [6:0] bcd_to_segment(input logic [3:0] value);
    logic [6:0] pat;
    pat = SEG_BLANK;
    case (value)
      4'd0:    pat = SEG_DIGIT_0;
      4'd1:    pat = SEG_DIGIT_1;
      4'd2:    pat = SEG_DIGIT_2;
      4'd3:    pat = SEG_DIGIT_3;
      4'd4:    pat = SEG_DIGIT_4;
      4'd5:    pat = SEG_DIGIT_5;
      4'd6:    pat = SEG_DIGIT_6;
      4'd7:    pat = SEG_DIGIT_7;
      4'd8:    pat = SEG_DIGIT_8;
      4'd9:    pat = SEG_DIGIT_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/segment_to_bcd.sv
// Combinational seven-segment pattern to BCD decode with a legality flag.
// Blank maps to BLANK_CODE and is legal; anything else unknown is illegal.
module segment_to_bcd
  import seven_segment_pkg::*;
(
  input  logic [6:0] pattern,
  output bcd_t       decoded
);

  always_comb begin
    decoded.legal = 1'b1;
    decoded.value = BLANK_CODE;
    case (pattern)
      SEG_DIGIT_0: decoded.value = 4'd0;
      SEG_DIGIT_1: decoded.value = 4'd1;
      SEG_DIGIT_2: decoded.value = 4'd2;
      SEG_DIGIT_3: decoded.value = 4'd3;
      SEG_DIGIT_4: decoded.value = 4'd4;
      SEG_DIGIT_5: decoded.value = 4'd5;
      SEG_DIGIT_6: decoded.value = 4'd6;
      SEG_DIGIT_7: decoded.value = 4'd7;
      SEG_DIGIT_8: decoded.value = 4'd8;
      SEG_DIGIT_9: decoded.value = 4'd9;
      SEG_BLANK:   decoded.value = BLANK_CODE;
      default:     decoded.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// Rebuilds a tens/units BCD pair from a multiplexed two-digit seven-segment bus.
// Define SEVEN_SEGMENT_DECODER_SYNC_EN to add a 2-flop input synchronizer.
module seven_segment_decoder
  import seven_segment_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] segments,
  input  logic       digit,
  output logic [3:0] ten_count,
  output logic [3:0] unit_count,
  output logic       valid,
  output logic       error
);

  localparam logic [7:0] StableTarget = 8'(STABLE_CYCLES);

  logic [6:0] seg_s;
  logic       dig_s;

`ifdef SEVEN_SEGMENT_DECODER_SYNC_EN
  logic [6:0] seg_meta_q, seg_sync_q;
  logic       dig_meta_q, dig_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_meta_q <= '0;
      seg_sync_q <= '0;
      dig_meta_q <= 1'b0;
      dig_sync_q <= 1'b0;
    end else begin
      seg_meta_q <= segments;
      seg_sync_q <= seg_meta_q;
      dig_meta_q <= digit;
      dig_sync_q <= dig_meta_q;
    end
  end

  assign seg_s = seg_sync_q;
  assign dig_s = dig_sync_q;
`else
  assign seg_s = segments;
  assign dig_s = digit;
`endif

  // Phase tracking and stability counting
  logic       digit_q;
  logic [6:0] seg_prev_q;
  logic [7:0] cnt_q, cnt_d;
  logic       acc_q, acc_d;
  logic       phase_start;
  logic       accept;

  assign phase_start = (dig_s != digit_q);

  always_comb begin
    cnt_d = 8'd1;
    if (!phase_start && (seg_s == seg_prev_q)) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end
  end

  // Counter hits the target once per run; acc_q blocks a second hit after a glitch.
  assign accept = (cnt_d == StableTarget) && (phase_start || !acc_q);
  assign acc_d  = phase_start ? accept : (acc_q | accept);

  bcd_t decoded;

  segment_to_bcd u_segment_to_bcd (
    .pattern (seg_s),
    .decoded (decoded)
  );

  // Frame FSM
  dec_state_e state_q, state_d;
  logic [3:0] unit_val_q, unit_val_d;
  logic       unit_legal_q, unit_legal_d;
  logic       unit_acc_q, unit_acc_d;
  logic [3:0] ten_count_q, ten_count_d;
  logic [3:0] unit_count_q, unit_count_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;
  logic       unit_cycle;
  logic       ten_cycle;

  always_comb begin
    state_d      = state_q;
    unit_val_d   = unit_val_q;
    unit_legal_d = unit_legal_q;
    unit_acc_d   = unit_acc_q;
    ten_count_d  = ten_count_q;
    unit_count_d = unit_count_q;
    valid_d      = 1'b0;
    error_d      = 1'b0;
    unit_cycle   = 1'b0;
    ten_cycle    = 1'b0;

    unique case (state_q)
      StSync: begin
        if (phase_start && !dig_s) begin
          state_d    = StUnit;
          unit_cycle = 1'b1;
        end
      end
      StUnit: begin
        if (phase_start && dig_s) begin
          if (unit_acc_q) begin
            state_d   = StTen;
            ten_cycle = 1'b1;
          end else begin
            state_d = StSync;
          end
        end else begin
          unit_cycle = 1'b1;
        end
      end
      StTen: begin
        if (phase_start && !dig_s) begin
          state_d    = StUnit;
          unit_cycle = 1'b1;
        end else begin
          ten_cycle = 1'b1;
        end
      end
      default: state_d = StSync;
    endcase

    if (unit_cycle) begin
      if (phase_start) begin
        unit_acc_d = 1'b0;
      end
      if (accept) begin
        unit_acc_d   = 1'b1;
        unit_val_d   = decoded.value;
        unit_legal_d = decoded.legal;
      end
    end

    if (ten_cycle && accept) begin
      if (unit_legal_q && decoded.legal) begin
        valid_d      = 1'b1;
        ten_count_d  = decoded.value;
        unit_count_d = unit_val_q;
      end else begin
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q      <= 1'b0;
      seg_prev_q   <= '0;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      state_q      <= StSync;
      unit_val_q   <= '0;
      unit_legal_q <= 1'b0;
      unit_acc_q   <= 1'b0;
      ten_count_q  <= '0;
      unit_count_q <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      digit_q      <= dig_s;
      seg_prev_q   <= seg_s;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      state_q      <= state_d;
      unit_val_q   <= unit_val_d;
      unit_legal_q <= unit_legal_d;
      unit_acc_q   <= unit_acc_d;
      ten_count_q  <= ten_count_d;
      unit_count_q <= unit_count_d;
      valid_q      <= valid_d;
      error_q      <= error_d;
    end
  end

  assign ten_count  = ten_count_q;
  assign unit_count = unit_count_q;
  assign valid      = valid_q;
  assign error      = error_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Bench for seven_segment_decoder: three instances (STABLE_CYCLES 1..3) share one bus
// and are checked every cycle against a phase/window model, plus directed frames.
module tb_seven_segment_decoder;

  localparam int NI = 3;
`ifdef SEVEN_SEGMENT_DECODER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] segments;
  logic       digit;
  logic [3:0] ten_count  [NI];
  logic [3:0] unit_count [NI];
  logic       valid      [NI];
  logic       error      [NI];

  always #5 clk = ~clk;

  seven_segment_decoder #(.STABLE_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .segments(segments), .digit(digit),
    .ten_count(ten_count[0]), .unit_count(unit_count[0]), .valid(valid[0]), .error(error[0])
  );
  seven_segment_decoder #(.STABLE_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(reset), .segments(segments), .digit(digit),
    .ten_count(ten_count[1]), .unit_count(unit_count[1]), .valid(valid[1]), .error(error[1])
  );
  seven_segment_decoder #(.STABLE_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .segments(segments), .digit(digit),
    .ten_count(ten_count[2]), .unit_count(unit_count[2]), .valid(valid[2]), .error(error[2])
  );

  logic [6:0] digit_pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};

  int n_cmp  = 0;
  int n_fail = 0;
  int n_valid [NI];
  int n_err   [NI];

  // Reference model state: shared phase history, per-instance acceptance/frame state.
  logic [6:0] p1_seg, p2_seg;
  logic       p1_dig, p2_dig;
  logic       m_prev_dig;
  bit         m_real;
  logic [6:0] m_hist [3];
  int         m_len;
  bit         m_acc [NI];
  bit         m_prev_units_ok [NI];
  logic [3:0] m_u_val [NI];
  bit         m_u_legal [NI];
  logic [3:0] m_ten [NI];
  logic [3:0] m_unit [NI];
  bit         m_valid [NI];
  bit         m_err [NI];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_decode(input logic [6:0] p, output bit legal, output logic [3:0] v);
    legal = 1'b0;
    v     = 4'hF;
    if (p == 7'h00) legal = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (digit_pat[i] == p) begin
        legal = 1'b1;
        v     = 4'(i);
      end
    end
  endtask

  task automatic model_step(input logic rst, input logic [6:0] seg, input logic dig);
    logic [6:0] es;
    logic       ed;
    bit         lg;
    logic [3:0] v;
    bit         same;
    if (rst) begin
      p1_seg = '0; p2_seg = '0; p1_dig = 1'b0; p2_dig = 1'b0;
      m_prev_dig = 1'b0; m_real = 1'b0; m_len = 0;
      for (int k = 0; k < NI; k++) begin
        m_acc[k] = 1'b0; m_prev_units_ok[k] = 1'b0; m_u_val[k] = '0; m_u_legal[k] = 1'b0;
        m_ten[k] = '0; m_unit[k] = '0; m_valid[k] = 1'b0; m_err[k] = 1'b0;
      end
      return;
    end
    if (LAT == 0) begin
      es = seg;
      ed = dig;
    end else begin
      es = p2_seg; ed = p2_dig;
      p2_seg = p1_seg; p2_dig = p1_dig;
      p1_seg = seg; p1_dig = dig;
    end
    for (int k = 0; k < NI; k++) begin
      m_valid[k] = 1'b0;
      m_err[k]   = 1'b0;
    end
    if (ed != m_prev_dig) begin
      // A tens phase can only finish a frame right after a real, accepted units phase.
      for (int k = 0; k < NI; k++) begin
        m_prev_units_ok[k] = (m_prev_dig == 1'b0) && m_real && m_acc[k];
        m_acc[k] = 1'b0;
      end
      m_real = 1'b1;
      m_len  = 0;
    end
    m_prev_dig = ed;
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = es;
    if (m_len < 3) m_len++;
    model_decode(es, lg, v);
    for (int k = 0; k < NI; k++) begin
      same = 1'b1;
      for (int j = 0; j <= k; j++) if (j < m_len && m_hist[j] != es) same = 1'b0;
      if (m_real && !m_acc[k] && m_len >= k + 1 && same) begin
        m_acc[k] = 1'b1;
        if (!ed) begin
          m_u_val[k]   = v;
          m_u_legal[k] = lg;
        end else if (m_prev_units_ok[k]) begin
          if (lg && m_u_legal[k]) begin
            m_valid[k] = 1'b1;
            m_ten[k]   = v;
            m_unit[k]  = m_u_val[k];
          end else begin
            m_err[k] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic [6:0] seg, input logic dig);
    reset    = rst;
    segments = seg;
    digit    = dig;
    @(posedge clk);
    model_step(rst, seg, dig);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("dut%0d valid", k), int'(valid[k]), int'(m_valid[k]));
      check($sformatf("dut%0d error", k), int'(error[k]), int'(m_err[k]));
      check($sformatf("dut%0d ten_count", k), int'(ten_count[k]), int'(m_ten[k]));
      check($sformatf("dut%0d unit_count", k), int'(unit_count[k]), int'(m_unit[k]));
      check($sformatf("dut%0d valid&error", k), int'(valid[k] & error[k]), 0);
      if (valid[k] === 1'b1) n_valid[k]++;
      if (error[k] === 1'b1) n_err[k]++;
    end
  endtask

  task automatic sep_units();
    for (int i = 0; i < LAT + 3; i++) step(1'b0, 7'h2A, 1'b0);
  endtask

  task automatic sep_tens();
    for (int i = 0; i < LAT + 4; i++) step(1'b0, 7'h2A, 1'b1);
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NI; k++) begin
      n_valid[k] = 0;
      n_err[k]   = 0;
    end
  endtask

  typedef struct {
    int         inst;
    logic [6:0] u_pat;
    logic [6:0] t_pat;
    int         len;
    int         frames;
    int         exp_valids;
    int         exp_errors;
    logic [3:0] exp_ten;
    logic [3:0] exp_unit;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [6:0] pat;
    int         len;

    vecs[0] = '{0, 7'h5B, 7'h66, 1, 1, 1, 0, 4'd4, 4'd2};
    vecs[1] = '{0, 7'h2A, 7'h3F, 1, 1, 0, 1, 4'd4, 4'd2};
    vecs[2] = '{0, 7'h7F, 7'h67, 2, 1, 1, 0, 4'd9, 4'd8};
    vecs[3] = '{0, 7'h00, 7'h00, 1, 1, 1, 0, 4'hF, 4'hF};
    vecs[4] = '{0, 7'h5B, 7'h66, 1, 5, 5, 0, 4'd4, 4'd2};
    vecs[5] = '{2, 7'h6D, 7'h06, 4, 1, 1, 0, 4'd1, 4'd5};
    vecs[6] = '{2, 7'h3F, 7'h3F, 2, 1, 0, 0, 4'd1, 4'd5};
    vecs[7] = '{1, 7'h5B, 7'h4F, 2, 1, 1, 0, 4'd3, 4'd2};
    vecs[8] = '{1, 7'h7F, 7'h7F, 1, 1, 0, 0, 4'd3, 4'd2};

    reset = 1'b1; segments = '0; digit = 1'b0;
    clear_counts();
    @(negedge clk);
    step(1'b1, 7'h00, 1'b0);
    step(1'b1, 7'h00, 1'b0);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset dut%0d ten", k), int'(ten_count[k]), 0);
      check($sformatf("reset dut%0d unit", k), int'(unit_count[k]), 0);
    end
    sep_units();
    sep_tens();

    foreach (vecs[r]) begin
      clear_counts();
      for (int f = 0; f < vecs[r].frames; f++) begin
        for (int i = 0; i < vecs[r].len; i++) step(1'b0, vecs[r].u_pat, 1'b0);
        for (int i = 0; i < vecs[r].len; i++) step(1'b0, vecs[r].t_pat, 1'b1);
      end
      sep_units();
      check($sformatf("vec%0d valids", r), n_valid[vecs[r].inst], vecs[r].exp_valids);
      check($sformatf("vec%0d errors", r), n_err[vecs[r].inst], vecs[r].exp_errors);
      check($sformatf("vec%0d ten", r), int'(ten_count[vecs[r].inst]), int'(vecs[r].exp_ten));
      check($sformatf("vec%0d unit", r), int'(unit_count[vecs[r].inst]), int'(vecs[r].exp_unit));
      sep_tens();
    end

    // Units pattern glitches before settling, STABLE_CYCLES=2
    clear_counts();
    step(1'b0, 7'h06, 1'b0);
    step(1'b0, 7'h5B, 1'b0);
    step(1'b0, 7'h5B, 1'b0);
    step(1'b0, 7'h4F, 1'b1);
    step(1'b0, 7'h4F, 1'b1);
    sep_units();
    check("glitch valids", n_valid[1], 1);
    check("glitch unit", int'(unit_count[1]), 2);
    check("glitch ten", int'(ten_count[1]), 3);
    sep_tens();

    // One-cycle reset in the middle of a tens phase
    for (int i = 0; i < 3; i++) step(1'b0, 7'h3F, 1'b0);
    step(1'b1, 7'h06, 1'b1);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("midreset dut%0d ten", k), int'(ten_count[k]), 0);
      check($sformatf("midreset dut%0d unit", k), int'(unit_count[k]), 0);
    end
    clear_counts();
    for (int i = 0; i < 3; i++) step(1'b0, 7'h06, 1'b1);
    sep_units();
    for (int k = 0; k < NI; k++) check($sformatf("midreset dut%0d valids", k), n_valid[k], 0);
    sep_tens();
    clear_counts();
    for (int i = 0; i < 3; i++) step(1'b0, 7'h4F, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 7'h5B, 1'b1);
    sep_units();
    check("postreset dut2 valids", n_valid[2], 1);
    check("postreset dut2 ten", int'(ten_count[2]), 2);
    check("postreset dut2 unit", int'(unit_count[2]), 3);

    // Random bus traffic against the model
    for (int ph = 0; ph < 600; ph++) begin
      len = int'($urandom_range(1, 5));
      if ($urandom_range(0, 9) < 8) begin
        pat = ($urandom_range(0, 10) == 10) ? 7'h00 : digit_pat[$urandom_range(0, 9)];
      end else begin
        pat = 7'($urandom);
      end
      for (int i = 0; i < len; i++) begin
        step(($urandom_range(0, 199) == 0), ($urandom_range(0, 6) == 0) ? 7'($urandom) : pat,
             1'(ph % 2));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_segment_decoder.md
# seven_segment_decoder

Receive-side counterpart of the multiplexed two-digit seven-segment driver. It samples a segment bus plus digit-select line, checks that each phase pattern is stable and legal, and rebuilds the tens/units BCD pair. Use it in loopback self-test of the frequency counter display path, and as a reader for an external two-digit seven-segment bus.

## Interface
Parameters:
- STABLE_CYCLES, default 1: consecutive identical samples within a phase required before that phase's pattern is accepted; legal range 1..255.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- segments  input  7  segment pattern; bit0=a … bit6=g, active-high
- digit  input  1  phase select; 0 = units digit on bus, 1 = tens digit on bus
- ten_count  output  4  last accepted tens value (0–9, 4'hF = blank)
- unit_count  output  4  last accepted units value (0–9, 4'hF = blank)
- valid  output  1  one-cycle pulse; new pair loaded into ten_count/unit_count
- error  output  1  one-cycle pulse; illegal pattern accepted in current frame

## Operation
- Legal patterns (hex, bit6..bit0): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7C, 7=07, 8=7F, 9=67, blank=00→4'hF. Any other pattern is illegal.
- A frame is one units phase (digit=0) followed by one tens phase (digit=1). A phase is a maximal run of cycles with constant digit.
- Phase start is the cycle where digit differs from its registered previous value digit_q. digit_q resets to 0.
- Stability counter: set to 1 on a phase's first cycle. On later cycles, increment (saturating) if segments equals its previous sample, else set to 1. The phase is accepted on the first cycle the counter equals STABLE_CYCLES. Acceptance happens at most once per phase.
- States:
  - SYNC (reset state): wait for a phase start with digit=0. That cycle is processed as the first UNIT cycle.
  - UNIT: on acceptance, latch decoded units value and its legal flag. On phase start with digit=1: go to TEN if units accepted, else go to SYNC.
  - TEN: on acceptance, complete the frame.
    - Both legal: load outputs and pulse valid.
    - Either illegal: pulse error; outputs hold.
    - On phase start with digit=0: go to UNIT, with that cycle as UNIT's first cycle. This applies whether or not tens was accepted. If tens was not accepted, the frame is silently discarded.
- Short phases (ended before acceptance) discard the frame with no error.
- valid and error are never asserted in the same cycle.

## Timing
- Reset values: ten_count=0, unit_count=0, valid=0, error=0, digit_q=0, state SYNC, counter 0.
- valid, error and the count outputs are registered. They update on the clock edge ending the tens acceptance cycle, so they are visible the following cycle.
- Digit toggling every cycle with STABLE_CYCLES=1: first valid occurs 2 cycles after the first units cycle. After that, one valid every 2 cycles.
- Reset mid-frame: partial frame discarded, outputs cleared, next reset-free cycle in SYNC.
- A frame can only be completed by the tens phase immediately following an accepted units phase.

## Configuration
- SEVEN_SEGMENT_DECODER_SYNC_EN defined:
  - segments and digit pass through a 2-flop synchronizer (reset to 0) before all logic.
  - All latencies grow by 2 cycles.
  - Required when the bus comes from off-chip.
- Not defined: inputs used directly; bus must be synchronous to clk.

## Structure
- Shared package seven_segment_pkg holds:
  - the ten digit pattern constants and the blank pattern;
  - the BLANK_CODE constant (4'hF);
  - the decoder state enum (SYNC, UNIT, TEN).
- Sub-module segment_to_bcd: combinational pattern → {legal, 4-bit value}. The driver's test bench reuses it.

## Test plan
- Loopback from driver with ten=4, unit=2, digit toggling every cycle → valid pulses; ten_count=4, unit_count=2; error never asserted.
- STABLE_CYCLES=3, phases of 4 cycles, units=6D, tens=06 → ten_count=1, unit_count=5 after the third tens cycle. With 2-cycle phases → no valid, no error.
- Units=2A (illegal), tens=3F → one error pulse; outputs keep previous 4/2; next legal frame (units=7F, tens=67) → valid, 9/8.
- Both phases 00 → valid, ten_count=unit_count=4'hF.
- Assert reset for 1 cycle during a tens phase → outputs 0 next cycle; no valid until a full new units+tens frame.
- Units pattern changes mid-phase with STABLE_CYCLES=2 (06, 5B, 5B) → units accepted as 2 on the third cycle; frame yields unit_count=2.
